// File: rtl/dmem_unit.sv
// dmem_unit: single-port 32-bit data memory with a valid/ready request and response handshake.
// Handles RISC-V byte, halfword and word loads and stores, with sign or zero extension on loads.
// Only one request is outstanding at a time.
// Optional build macro DMEM_MISALIGN_TRAP_EN: misaligned halfword/word accesses become error responses.
// Without the macro, the misaligned low address bits are cleared and the access proceeds.
module dmem_unit #(
  parameter int N         = 12,
  parameter int INIT_ZERO = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_width,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int DEPTH = 1 << N;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [1:0]  off_q;
  logic [2:0]  width_q;
  logic [31:0] rd_word_q;

  logic        accept;
  logic        bad_width, bad_store, bad_range, misalign, req_err;
  logic [1:0]  eff_off;
  logic [3:0]  lane_en;
  logic [31:0] lane_data;
  logic [N-1:0] word_idx;
  logic        wr_en, rd_en;

  // Pull the addressed byte/halfword out of a word and extend it to 32 bits.
  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] off,
                                          input logic [2:0] f);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f)
      3'b000:  r = 32'(b);
      3'b100:  r = {24'd0, b};
      3'b001:  r = 32'(h);
      3'b101:  r = {16'd0, h};
      3'b010:  r = word;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  assign accept   = i_req_valid && o_req_ready;
  assign word_idx = i_req_addr[N+1:2];

  // Decode the incoming request: error conditions, effective byte offset, byte lanes.
  always_comb begin
    bad_width = (i_req_width == 3'b011) || (i_req_width == 3'b110) || (i_req_width == 3'b111);
    bad_store = i_req_we && i_req_width[2];
    bad_range = |i_req_addr[31:N+2];
`ifdef DMEM_MISALIGN_TRAP_EN
    misalign  = ((i_req_width[1:0] == 2'b01) && i_req_addr[0]) ||
                ((i_req_width[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
`else
    misalign  = 1'b0;
`endif
    req_err   = bad_width || bad_store || bad_range || misalign;

    // Halfword and word accesses are forced onto their natural alignment.
    case (i_req_width[1:0])
      2'b00:   eff_off = i_req_addr[1:0];
      2'b01:   eff_off = {i_req_addr[1], 1'b0};
      default: eff_off = 2'b00;
    endcase

    // The store data is replicated across lanes so that each enabled lane sees its own bytes.
    case (i_req_width[1:0])
      2'b00: begin
        lane_en   = 4'b0001 << eff_off;
        lane_data = {4{i_req_wdata[7:0]}};
      end
      2'b01: begin
        lane_en   = eff_off[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{i_req_wdata[15:0]}};
      end
      default: begin
        lane_en   = 4'b1111;
        lane_data = i_req_wdata;
      end
    endcase

    wr_en = accept && !req_err && i_req_we;
    rd_en = accept && !req_err && !i_req_we;
  end

  // Storage: the contents are not reset. Stores write at the acceptance edge. Loads capture the word at the same edge.
  if (INIT_ZERO != 0) begin : g_mem
    logic [31:0] mem_q [DEPTH] = '{default: '0};
    always_ff @(posedge i_clk) begin
      for (int b = 0; b < 4; b++)
        if (wr_en && lane_en[b]) mem_q[word_idx][8*b +: 8] <= lane_data[8*b +: 8];
      if (rd_en) rd_word_q <= mem_q[word_idx];
    end
  end else begin : g_mem
    logic [31:0] mem_q [DEPTH];
    always_ff @(posedge i_clk) begin
      for (int b = 0; b < 4; b++)
        if (wr_en && lane_en[b]) mem_q[word_idx][8*b +: 8] <= lane_data[8*b +: 8];
      if (rd_en) rd_word_q <= mem_q[word_idx];
    end
  end

  // Latch the load-extraction controls at acceptance. These registers need no reset.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      off_q   <= eff_off;
      width_q <= i_req_width;
    end
  end

  // State and response registers. Reset clears them immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state logic and response data. The response is held while waiting in RESP.
  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          rsp_rdata_d = 32'd0;
          rsp_err_d   = req_err;
          state_d     = (req_err || i_req_we) ? S_RESP : S_READ;
        end
      end
      S_READ: begin
        rsp_rdata_d = extract(rd_word_q, off_q, width_q);
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (i_rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs are decoded directly from the current state.
  always_comb begin
    o_req_ready = (state_q == S_IDLE);
    o_rsp_valid = (state_q == S_RESP);
    o_rsp_rdata = rsp_rdata_q;
    o_rsp_err   = rsp_err_q;
  end

endmodule

// File: tb/tb_dmem_unit.sv
// Directed testbench for dmem_unit: stores and loads of each width, sign/zero extension,
// error responses, misaligned access, response back-pressure, and reset while a load is in flight.
module tb_dmem_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_width;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic [31:0] held;

  dmem_unit #(.N(12), .INIT_ZERO(0)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
    .i_req_width(req_width), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait (bounded) for its response, and accept the response.
  task automatic do_req(input logic we, input logic [2:0] w, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rdo, output logic ero,
                        output int lato);
    logic got;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_width = w; req_addr = a; req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lato = 0; got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      lato++;
      if (rsp_valid) got = 1'b1;
    end
    chk("rsp_arrived", 32'(got), 32'd1);
    rdo = rsp_rdata; ero = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_width = 3'b010;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    #12;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_err",   32'(rsp_err),   32'd0);
    chk("reset_rsp_rdata", rsp_rdata,      32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_ready", 32'(req_ready), 32'd1);

    // Store a word, then read it back with each load width.
    do_req(1'b1, 3'b010, 32'h10, 32'h8000_80F1, rd, er, lat);
    chk("sw10_rdata", rd, 32'd0); chk("sw10_err", 32'(er), 32'd0); chk("sw10_lat", 32'(lat), 32'd1);
    do_req(1'b0, 3'b000, 32'h10, 32'd0, rd, er, lat);
    chk("lb10", rd, 32'hFFFF_FFF1); chk("lb10_lat", 32'(lat), 32'd2);
    do_req(1'b0, 3'b100, 32'h10, 32'd0, rd, er, lat);
    chk("lbu10", rd, 32'h0000_00F1);
    do_req(1'b0, 3'b001, 32'h12, 32'd0, rd, er, lat);
    chk("lh12", rd, 32'hFFFF_8000);
    do_req(1'b0, 3'b101, 32'h12, 32'd0, rd, er, lat);
    chk("lhu12", rd, 32'h0000_8000); chk("lhu12_err", 32'(er), 32'd0);

    // Partial stores must merge into the existing word.
    do_req(1'b1, 3'b010, 32'h20, 32'h1122_3344, rd, er, lat);
    do_req(1'b1, 3'b000, 32'h21, 32'h0000_00AA, rd, er, lat);
    chk("sb21_err", 32'(er), 32'd0);
    do_req(1'b1, 3'b001, 32'h22, 32'h0000_BEEF, rd, er, lat);
    do_req(1'b0, 3'b010, 32'h20, 32'd0, rd, er, lat);
    chk("lw20_merge", rd, 32'hBEEF_AA44); chk("lw20_err", 32'(er), 32'd0);

    // Error responses.
    do_req(1'b0, 3'b010, 32'h4000, 32'd0, rd, er, lat);
    chk("oor_err", 32'(er), 32'd1); chk("oor_rdata", rd, 32'd0); chk("oor_lat", 32'(lat), 32'd1);
    do_req(1'b0, 3'b011, 32'h20, 32'd0, rd, er, lat);
    chk("w011_err", 32'(er), 32'd1);
    do_req(1'b1, 3'b100, 32'h20, 32'h0000_0055, rd, er, lat);
    chk("sbu_err", 32'(er), 32'd1);
    do_req(1'b0, 3'b010, 32'h20, 32'd0, rd, er, lat);
    chk("sbu_no_write", rd, 32'hBEEF_AA44);

    // Misaligned halfword load.
    do_req(1'b0, 3'b001, 32'h21, 32'd0, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("lh21_err", 32'(er), 32'd1); chk("lh21_rdata", rd, 32'd0);
`else
    chk("lh21_err", 32'(er), 32'd0); chk("lh21_rdata", rd, 32'hFFFF_AA44);
    do_req(1'b1, 3'b010, 32'h32, 32'h1234_5678, rd, er, lat);
    do_req(1'b0, 3'b010, 32'h30, 32'd0, rd, er, lat);
    chk("sw32_aligned", rd, 32'h1234_5678);
`endif

    // Back-pressure: the response must hold steady, and a new request must be refused.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_width = 3'b010; req_addr = 32'h10;
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hDEAD_BEEF;
    @(negedge clk); @(negedge clk);
    chk("stall_valid0", 32'(rsp_valid), 32'd1);
    held = rsp_rdata;
    chk("stall_rdata", held, 32'h8000_80F1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_hold", rsp_rdata, held);
      chk("stall_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    do_req(1'b0, 3'b010, 32'h10, 32'd0, rd, er, lat);
    chk("stall_not_accepted", rd, 32'h8000_80F1);

    // Reset while a load is in flight: the response is abandoned and memory is kept.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_width = 3'b010; req_addr = 32'h20;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_read_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rst_read_no_rsp", 32'(rsp_valid), 32'd0);
    chk("rst_read_ready", 32'(req_ready), 32'd1);
    do_req(1'b0, 3'b010, 32'h20, 32'd0, rd, er, lat);
    chk("after_rst_lw", rd, 32'hBEEF_AA44);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_unit.md
DMEM_UNIT -- requirements
Module: dmem_unit

Interface
REQ-001 Parameter N, default 12: word-address bits; capacity is 2^N 32-bit words (4*2^N bytes).
REQ-002 Parameter INIT_ZERO, default 0: 1 = simulation-time zero-fill of storage; 0 = contents undefined.
REQ-003 i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous and active-low.
REQ-005 i_req_valid  in  1  request present.
REQ-006 o_req_ready  out  1  unit can accept a request this cycle.
REQ-007 i_req_we  in  1  1 = store, 0 = load.
REQ-008 i_req_width  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 i_req_addr  in  32  byte address.
REQ-010 i_req_wdata  in  32  store data, LSB-aligned.
REQ-011 o_rsp_valid  out  1  response present.
REQ-012 i_rsp_ready  in  1  consumer accepts response.
REQ-013 o_rsp_rdata  out  32  load data, extended per width; 0 for stores and errors.
REQ-014 o_rsp_err  out  1  request rejected (see REQ-020).

Function
REQ-015 FSM states IDLE, READ, RESP; o_req_ready = 1 only in IDLE.
REQ-016 Request accepted when i_req_valid && o_req_ready; request fields sampled only at that edge.
REQ-017 Accepted valid store: storage updated at acceptance edge, only byte lanes selected by addr[1:0] and width (B: 1 lane, H: lanes {addr[1],0..1}, W: all 4); state -> RESP; o_rsp_valid asserted the next cycle (latency 1).
REQ-018 Accepted valid load: word at addr[N+1:2] read at acceptance edge, state -> READ; next edge registers extracted data into o_rsp_rdata, state -> RESP (latency 2).
REQ-019 Load extraction: B/BU select byte addr[1:0]; H/HU select halfword addr[1]; B/H sign-extend from bit 7/15 of the selected field; BU/HU zero-extend; W passes the word.
REQ-020 Error: width code 011, 110, 111, or a store with width 100/101, or addr[31:N+2] != 0 -> no storage write, state -> RESP, o_rsp_err = 1, o_rsp_rdata = 0, latency 1.
REQ-021 In RESP, o_rsp_valid, o_rsp_rdata, o_rsp_err held stable until i_rsp_ready; on o_rsp_valid && i_rsp_ready, state -> IDLE, o_rsp_valid deasserts next cycle.
REQ-022 One outstanding request maximum; back-to-back throughput: 1 store per 2 cycles, 1 load per 3 cycles with i_rsp_ready held high.
REQ-023 A load following a store to the same byte returns the stored value (no stale read).
REQ-024 o_rsp_err = 0 and o_rsp_rdata = 0 for every successful store response.

Reset
REQ-025 i_rst_n low -> immediately: state IDLE, o_rsp_valid = 0, o_rsp_err = 0, o_rsp_rdata = 0; o_req_ready = 1 from the first edge after release.
REQ-026 Reset during READ or RESP abandons the response; a store already committed at its acceptance edge stays written.
REQ-027 Storage contents not affected by reset.

Configuration
REQ-028 Macro DMEM_MISALIGN_TRAP_EN defined: H/HU with addr[0] = 1 or W with addr[1:0] != 0 is an error per REQ-020.
REQ-029 Macro DMEM_MISALIGN_TRAP_EN undefined: misaligned low address bits silently cleared (H: addr[0]; W: addr[1:0]) and the access proceeds as aligned; no error raised.

Verification
REQ-030 SW 0x8000_80F1 @0x10, then LB @0x10 -> rdata 0xFFFF_FFF1; LBU @0x10 -> 0x0000_00F1; LH @0x12 -> 0xFFFF_8000; LHU @0x12 -> 0x0000_8000.
REQ-031 SW 0x1122_3344 @0x20, SB 0xAA @0x21, SH 0xBEEF @0x22, LW @0x20 -> 0xBEEF_AA44, err 0.
REQ-032 LW @0x4000 with N=12 -> err 1, rdata 0, latency 1; width 011 -> err 1; SB width 100 -> err 1, memory unchanged.
REQ-033 LH @0x21: with DMEM_MISALIGN_TRAP_EN -> err 1; without -> data of halfword @0x20, err 0.
REQ-034 Load accepted, i_rsp_ready low 5 cycles -> response stable, o_req_ready 0 throughout; i_req_valid asserted meanwhile is not accepted.
REQ-035 i_rst_n pulsed low in READ -> o_rsp_valid 0 immediately, no response delivered, next LW returns correct data.
